// File: rtl/memory_access_pkg.sv
// rtl/memory_access_pkg.sv - shared state codes and MEM/WB record for the memory-access stage
package memory_access_pkg;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    typedef struct packed {
        logic [31:0] alu_out;
        logic [31:0] rdata;
        logic        mem_to_reg;
        logic        reg_write;
        logic [4:0]  rd;
    } mem_wb_t;

    localparam mem_wb_t MEM_WB_BUBBLE = '0;

endpackage

// File: rtl/memory_access_mem_wb_reg.sv
// rtl/memory_access_mem_wb_reg.sv - MEM/WB pipeline register, async active-low clear
module mem_wb_reg
    import memory_access_pkg::*;
(
    input  logic    clk,
    input  logic    reset_n,
    input  mem_wb_t d,
    output mem_wb_t q
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q <= MEM_WB_BUBBLE;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/memory_access.sv
// rtl/memory_access.sv - MEM stage: data-memory handshake, stall/timeout/fault handling, MEM/WB register
module memory_access
    import memory_access_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] EX_MEM_alu_out,
    input  logic        EX_MEM_mem_to_reg,
    input  logic        EX_MEM_reg_write,
    input  logic        EX_MEM_mem_write,
    input  logic        EX_MEM_mem_read,
    input  logic [31:0] EX_MEM_dataB,
    input  logic [4:0]  EX_MEM_rd,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        mem_stall,
    output logic        mem_fault,
    output logic [31:0] MEM_WB_alu_out,
    output logic [31:0] MEM_WB_rdata,
    output logic        MEM_WB_mem_to_reg,
    output logic        MEM_WB_reg_write,
    output logic [4:0]  MEM_WB_rd,
    output logic [31:0] wb_data
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [0:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          fault_q, fault_d;
    logic          pending, aligned, in_wait, timeout, req_raw, misaligned, load_done;
    mem_wb_t       mem_wb_d, mem_wb_q;

    assign pending    = EX_MEM_mem_read | EX_MEM_mem_write;
    assign aligned    = (EX_MEM_alu_out[1:0] == 2'b00);
    assign in_wait    = (state_q == ST_WAIT);
    assign timeout    = in_wait & ~dmem_ack & (cnt_q == CW'(TIMEOUT_CYCLES));
    assign req_raw    = in_wait | (pending & aligned);
    assign misaligned = ~in_wait & pending & ~aligned;
    assign load_done  = req_raw & dmem_ack & ~EX_MEM_mem_write;

    // Gated by reset so an in-flight request drops the instant reset asserts.
    assign dmem_req   = reset_n & req_raw;
    assign mem_stall  = reset_n & (in_wait ? (~dmem_ack & ~timeout)
                                           : (pending & aligned & ~dmem_ack));

    assign dmem_we    = EX_MEM_mem_write;
    assign dmem_addr  = EX_MEM_alu_out;
    assign dmem_wdata = EX_MEM_dataB;

    assign fault_d    = misaligned | timeout;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (in_wait) begin
            if (dmem_ack || timeout) begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end else begin
                cnt_d   = cnt_q + CW'(1);
            end
        end else if (pending && aligned && !dmem_ack) begin
            state_d = ST_WAIT;
            cnt_d   = CW'(1);
        end
    end

    always_comb begin
        mem_wb_d = MEM_WB_BUBBLE;
        if (!mem_stall && !fault_d) begin
            mem_wb_d.alu_out    = EX_MEM_alu_out;
            mem_wb_d.rdata      = load_done ? dmem_rdata : 32'd0;
            mem_wb_d.mem_to_reg = EX_MEM_mem_to_reg;
            mem_wb_d.reg_write  = EX_MEM_reg_write;
            mem_wb_d.rd         = EX_MEM_rd;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fault_q <= fault_d;
        end
    end

    mem_wb_reg u_mem_wb_reg (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (mem_wb_d),
        .q       (mem_wb_q)
    );

    assign mem_fault         = fault_q;
    assign MEM_WB_alu_out    = mem_wb_q.alu_out;
    assign MEM_WB_rdata      = mem_wb_q.rdata;
    assign MEM_WB_mem_to_reg = mem_wb_q.mem_to_reg;
    assign MEM_WB_reg_write  = mem_wb_q.reg_write;
    assign MEM_WB_rd         = mem_wb_q.rd;
    assign wb_data           = mem_wb_q.mem_to_reg ? mem_wb_q.rdata : mem_wb_q.alu_out;

endmodule

// File: doc/memory_access.md
MEMORY_ACCESS -- requirements
Module: memory_access

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16: max cycles an access may wait for dmem_ack before abort.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 reset_n  input  1  reset, asynchronous, active-low.
REQ-004 EX_MEM_alu_out  input  32  ALU result / data memory address.
REQ-005 EX_MEM_mem_to_reg, EX_MEM_reg_write, EX_MEM_mem_write, EX_MEM_mem_read  input  1 each  control bits from the EX/MEM register.
REQ-006 EX_MEM_dataB  input  32  store data; EX_MEM_rd  input  5  destination register.
REQ-007 dmem_req  output  1  request valid; dmem_we  output  1  1=store, 0=load.
REQ-008 dmem_addr  output  32  word address; dmem_wdata  output  32  store data.
REQ-009 dmem_ack  input  1  access complete; dmem_rdata  input  32  load data, valid when dmem_ack=1 and dmem_we=0.
REQ-010 mem_stall  output  1  freeze request to the hazard unit.
REQ-011 mem_fault  output  1  one-cycle pulse on misaligned access or timeout.
REQ-012 MEM_WB_alu_out, MEM_WB_rdata  output  32 each; MEM_WB_mem_to_reg, MEM_WB_reg_write  output  1 each; MEM_WB_rd  output  5: MEM/WB register.
REQ-013 wb_data  output  32  writeback/forwarding value.

Function
REQ-014 Access pending = EX_MEM_mem_read | EX_MEM_mem_write; aligned = EX_MEM_alu_out[1:0]==2'b00.
REQ-015 FSM states IDLE, WAIT; reset state IDLE.
REQ-016 IDLE: dmem_req = pending & aligned, combinational, same cycle EX_MEM inputs appear.
REQ-017 IDLE, req=1, dmem_ack=1: access completes that cycle, zero stall, stay IDLE.
REQ-018 IDLE, req=1, dmem_ack=0: go WAIT, clear wait counter to 1.
REQ-019 WAIT: dmem_req=1; dmem_ack=1 -> complete, IDLE; else counter increments.
REQ-020 WAIT with counter == TIMEOUT_CYCLES and no ack: abort, dmem_req low next cycle, mem_fault pulse, go IDLE, bubble into MEM/WB.
REQ-021 dmem_we = EX_MEM_mem_write; dmem_addr = EX_MEM_alu_out; dmem_wdata = EX_MEM_dataB; all combinational.
REQ-022 Both mem_read and mem_write set: treated as store (dmem_we=1).
REQ-023 mem_stall = (pending & aligned & ~dmem_ack) in IDLE, or ~dmem_ack & ~timeout in WAIT.
REQ-024 EX_MEM inputs are held stable by the pipeline while mem_stall=1; the block does not re-latch them.
REQ-025 Misaligned pending access: no dmem_req, no stall, mem_fault pulse next cycle, bubble into MEM/WB.
REQ-026 MEM/WB update each cycle mem_stall=0: alu_out, rd, mem_to_reg, reg_write copied; MEM_WB_rdata = dmem_rdata on a completed load, else 0.
REQ-027 While mem_stall=1: MEM/WB loaded with bubble (reg_write=0, mem_to_reg=0, rd=0, data 0).
REQ-028 Bubble (faulted access): reg_write=0, mem_to_reg=0, rd=0, data 0.
REQ-029 Non-memory instruction: passes through in one cycle, no dmem_req.
REQ-030 wb_data = MEM_WB_mem_to_reg ? MEM_WB_rdata : MEM_WB_alu_out.

Reset
REQ-031 reset_n low: state IDLE, counter 0, mem_fault 0, all MEM_WB_* 0, immediately (asynchronous).
REQ-032 Reset during WAIT: dmem_req deasserts asynchronously; a late dmem_ack after reset release is ignored in IDLE when no access is pending.

Structure
REQ-033 Shared package holds state enum (IDLE, WAIT) and the bubble constant; ALU opcode constants stay in the existing package.
REQ-034 No sub-module required; the optional MEM/WB register is a sub-module named mem_wb_reg.

Verification
REQ-035 Load x5, addr 0x100, ack same cycle, rdata 0xDEADBEEF -> no stall; next cycle MEM_WB_rd=5, MEM_WB_rdata=0xDEADBEEF, wb_data=0xDEADBEEF.
REQ-036 Store addr 0x200, data 0x12345678, ack after 3 cycles -> dmem_req/we high for 4 cycles, mem_stall high for 3, MEM_WB_reg_write=0.
REQ-037 Load addr 0x102 -> no dmem_req, mem_fault pulse, MEM_WB bubble.
REQ-038 Load with no ack, TIMEOUT_CYCLES=16 -> stall for 16 cycles, mem_fault pulse, FSM returns to IDLE.
REQ-039 ADD result 0x7 to x3 -> MEM_WB_alu_out=0x7, reg_write=1, wb_data=0x7, dmem_req never high.
REQ-040 reset_n low in WAIT cycle 2 -> dmem_req low immediately, all outputs 0; first load after release completes normally.
